ppu_video_mem_responder: RTL

//  Responder side of the PPU video-memory read port: owns VRAM (8000-9FFF, 8 KiB) and OAM (FE00-FE9F, 160 B).

---
 rtl/ppu_video_mem_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ppu_video_mem_responder.sv
// Video-memory responder: VRAM/OAM arrays, PPU fetch port, CPU MMIO port with mode lockout,
// and the FF46 OAM DMA engine (built only when PPU_DMA_EN is defined).
module ppu_video_mem_responder #(
  parameter int DMA_CYCLES_PER_BYTE = 4,
  parameter int DMA_LEN             = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  input  logic [1:0]  PPU_MODE,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_DATA_in,
  output logic        DMA_RD,
  output logic [15:0] DMA_ADDR,
  input  logic [7:0]  DMA_DATA,
  output logic        DMA_ACTIVE
);

  logic [7:0] vram [0:8191];
  logic [7:0] oam  [0:159];
  logic [7:0] ff46_q;

  logic       dma_active;
  logic       dma_we;
  logic [7:0] dma_idx;

  logic cpu_vram, cpu_oam, cpu_ff46, ppu_vram, ppu_oam;
  logic cpu_vram_ok, cpu_oam_ok;

  assign cpu_vram = (ADDR[15:13] == 3'b100);
  assign cpu_oam  = (ADDR >= 16'hFE00) && (ADDR <= 16'hFE9F);
  assign cpu_ff46 = (ADDR == 16'hFF46);
  assign ppu_vram = (PPU_ADDR[15:13] == 3'b100);
  assign ppu_oam  = (PPU_ADDR >= 16'hFE00) && (PPU_ADDR <= 16'hFE9F);

  // VRAM is locked in DRAW; OAM in SCAN/DRAW (mode bit 1) or while DMA owns it.
  assign cpu_vram_ok = cpu_vram && (PPU_MODE != 2'd3);
  assign cpu_oam_ok  = cpu_oam && !PPU_MODE[1] && !dma_active;

  assign DMA_ACTIVE = dma_active;

  // Array contents survive reset, so the write ports have no reset term.
  always_ff @(posedge clk) begin
    if (WR && cpu_vram_ok)
      vram[ADDR[12:0]] <= MMIO_DATA_out;
    if (dma_we)
      oam[dma_idx] <= DMA_DATA;
    else if (WR && cpu_oam_ok)
      oam[ADDR[7:0]] <= MMIO_DATA_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PPU_DATA_in <= 8'hFF;
    end else if (PPU_RD) begin
      if (ppu_vram)
        PPU_DATA_in <= vram[PPU_ADDR[12:0]];
      else if (ppu_oam && !dma_active)
        PPU_DATA_in <= oam[PPU_ADDR[7:0]];
      else
        PPU_DATA_in <= 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MMIO_DATA_in <= 8'hFF;
    end else if (RD) begin
      if (cpu_vram_ok)
        MMIO_DATA_in <= vram[ADDR[12:0]];
      else if (cpu_oam_ok)
        MMIO_DATA_in <= oam[ADDR[7:0]];
      else if (cpu_ff46)
        MMIO_DATA_in <= ff46_q;
      else
        MMIO_DATA_in <= 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ff46_q <= 8'h00;
    else if (WR && cpu_ff46)
      ff46_q <= MMIO_DATA_out;
  end

`ifdef PPU_DMA_EN
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [3:0] WAIT_LAST = 4'(DMA_CYCLES_PER_BYTE - 3);
  localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);

  logic [2:0] state;
  logic [7:0] idx;
  logic [3:0] wait_cnt;
  logic       byte_done;

  // With two cycles per byte there is no WAIT phase; the byte ends in WR.
  assign byte_done = ((state == S_WR) && (DMA_CYCLES_PER_BYTE == 2)) ||
                     ((state == S_WAIT) && (wait_cnt == WAIT_LAST));

  assign DMA_RD   = (state == S_RD);
  assign DMA_ADDR = {ff46_q, idx};
  assign dma_we   = (state == S_WR);
  assign dma_idx  = idx;

  // DMA_ACTIVE trails the state by one cycle, covering the final IDLE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      idx        <= 8'h00;
      wait_cnt   <= 4'h0;
      dma_active <= 1'b0;
    end else begin
      dma_active <= (state != S_IDLE);
      if (WR && cpu_ff46) begin
        state <= S_START;
        idx   <= 8'h00;
      end else begin
        case (state)
          S_START: state <= S_RD;
          S_RD:    state <= S_WR;
          S_WR, S_WAIT: begin
            if (byte_done) begin
              if (idx == LAST_IDX) begin
                state <= S_IDLE;
              end else begin
                idx   <= idx + 8'd1;
                state <= S_RD;
              end
            end else begin
              state    <= S_WAIT;
              wait_cnt <= (state == S_WR) ? 4'h0 : wait_cnt + 4'h1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
`else
  logic cfg_unused;

  assign cfg_unused = (DMA_CYCLES_PER_BYTE < 2) || (DMA_LEN < 1);
  assign DMA_RD     = 1'b0;
  assign DMA_ADDR   = 16'h0000;
  assign dma_active = 1'b0;
  assign dma_we     = 1'b0;
  assign dma_idx    = 8'h00;
`endif

endmodule
